// File: rtl/card_hit_finder.sv
// Finds the lowest-index active card whose rectangle contains a query point.
// Latency: hit at card k -> k+1 edges after accept, miss -> 16; result held until result_ready.
module card_hit_finder #(
    parameter int CARD_W = 80,
    parameter int CARD_H = 100
) (
    input  logic         FPGA_Clk,
    input  logic         FPGA_Rst_n,
    input  logic [159:0] cardX_bus,
    input  logic [159:0] cardY_bus,
    input  logic [15:0]  card_active,
    input  logic [9:0]   queryX,
    input  logic [9:0]   queryY,
    input  logic         query_valid,
    output logic         query_ready,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         hit,
    output logic [3:0]   hit_index
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [9:0]  snap_x_q [16];
    logic [9:0]  snap_y_q [16];
    logic [15:0] active_q;
    logic [9:0]  qx_q;
    logic [9:0]  qy_q;
    logic [3:0]  idx_q;
    logic        hit_q;
    logic [3:0]  hit_index_q;
    logic        result_valid_q;

    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic [10:0] x_lim;
    logic [10:0] y_lim;
    logic [10:0] qx_w;
    logic [10:0] qy_w;
    logic        cur_hit;

    // Limits are 11 bits so a card near the right edge (X=1000) never wraps.
    always_comb begin
        cur_x   = {1'b0, snap_x_q[idx_q]};
        cur_y   = {1'b0, snap_y_q[idx_q]};
        x_lim   = cur_x + 11'(CARD_W);
        y_lim   = cur_y + 11'(CARD_H);
        qx_w    = {1'b0, qx_q};
        qy_w    = {1'b0, qy_q};
        cur_hit = active_q[idx_q]
                  && (qx_w >= cur_x) && (qx_w < x_lim)
                  && (qy_w >= cur_y) && (qy_w < y_lim);
    end

    always_ff @(posedge FPGA_Clk or negedge FPGA_Rst_n) begin
        if (!FPGA_Rst_n) begin
            state_q        <= IDLE;
            active_q       <= '0;
            qx_q           <= '0;
            qy_q           <= '0;
            idx_q          <= '0;
            hit_q          <= 1'b0;
            hit_index_q    <= '0;
            result_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                snap_x_q[i] <= '0;
                snap_y_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (query_valid) begin
                        qx_q     <= queryX;
                        qy_q     <= queryY;
                        active_q <= card_active;
                        idx_q    <= '0;
                        for (int i = 0; i < 16; i++) begin
                            snap_x_q[i] <= cardX_bus[10*i +: 10];
                            snap_y_q[i] <= cardY_bus[10*i +: 10];
                        end
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_hit) begin
                        hit_q          <= 1'b1;
                        hit_index_q    <= idx_q;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else if (idx_q == 4'd15) begin
                        hit_q          <= 1'b0;
                        hit_index_q    <= '0;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    result_valid_q <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign query_ready  = (state_q == IDLE);
    assign result_valid = result_valid_q;
    assign hit          = hit_q;
    assign hit_index    = hit_index_q;

endmodule

// File: tb/tb_card_hit_finder.sv
// Bench for card_hit_finder: grid layout queries, edge/overlap/wrap cases, stall and reset.
module tb_card_hit_finder;

    logic         FPGA_Clk;
    logic         FPGA_Rst_n;
    logic [159:0] cardX_bus;
    logic [159:0] cardY_bus;
    logic [15:0]  card_active;
    logic [9:0]   queryX;
    logic [9:0]   queryY;
    logic         query_valid;
    logic         query_ready;
    logic         result_valid;
    logic         result_ready;
    logic         hit;
    logic [3:0]   hit_index;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       hit;
        logic [3:0] idx;
        int         lat;
        string      tag;
    } exp_t;

    exp_t exp_q [$];

    card_hit_finder dut (
        .FPGA_Clk     (FPGA_Clk),
        .FPGA_Rst_n   (FPGA_Rst_n),
        .cardX_bus    (cardX_bus),
        .cardY_bus    (cardY_bus),
        .card_active  (card_active),
        .queryX       (queryX),
        .queryY       (queryY),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .hit          (hit),
        .hit_index    (hit_index)
    );

    initial FPGA_Clk = 1'b0;
    always #5 FPGA_Clk = ~FPGA_Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic set_layout();
        for (int i = 0; i < 16; i++) begin
            cardX_bus[10*i +: 10] = 10'(40 + 120 * (i % 4));
            cardY_bus[10*i +: 10] = 10'(20 + 115 * (i / 4));
        end
        card_active = 16'hFFFF;
    endtask

    // Drive one query, measure latency from accept edge, compare against scoreboard, hand off.
    task automatic run_query(input logic [9:0] qx, input logic [9:0] qy,
                             input logic eh, input logic [3:0] ei, input int el,
                             input string tag, input int stall, input bit perturb);
        exp_t e;
        int   lat;
        int   bound;
        int   unstable;
        exp_q.push_back('{eh, ei, el, tag});
        @(negedge FPGA_Clk);
        queryX      = qx;
        queryY      = qy;
        query_valid = 1'b1;
        bound = 0;
        while (!query_ready && bound < 50) begin
            @(negedge FPGA_Clk);
            bound++;
        end
        @(posedge FPGA_Clk);
        #1;
        query_valid = 1'b0;
        if (perturb) begin
            queryX    = 10'd45;
            queryY    = 10'd25;
            cardX_bus = '0;
        end
        lat = 0;
        do begin
            @(posedge FPGA_Clk);
            #1;
            lat++;
        end while (!result_valid && lat < 40);
        e = exp_q.pop_front();
        chk({e.tag, "_hit"}, 32'(hit), 32'(e.hit));
        chk({e.tag, "_idx"}, 32'(hit_index), 32'(e.idx));
        chk({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
        if (stall > 0) begin
            unstable = 0;
            for (int s = 0; s < stall; s++) begin
                @(posedge FPGA_Clk);
                #1;
                if (!result_valid || query_ready || hit !== e.hit || hit_index !== e.idx)
                    unstable++;
            end
            chk({e.tag, "_stall_unstable"}, 32'(unstable), 32'd0);
        end
        @(negedge FPGA_Clk);
        result_ready = 1'b1;
        @(posedge FPGA_Clk);
        #1;
        result_ready = 1'b0;
        chk({e.tag, "_rv_cleared"}, 32'(result_valid), 32'd0);
        chk({e.tag, "_qr_back"}, 32'(query_ready), 32'd1);
        if (perturb) set_layout();
    endtask

    initial begin
        int spurious;
        FPGA_Rst_n   = 1'b0;
        query_valid  = 1'b0;
        result_ready = 1'b0;
        queryX       = '0;
        queryY       = '0;
        cardX_bus    = '0;
        cardY_bus    = '0;
        card_active  = '0;
        set_layout();
        #2;
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_hit_index", 32'(hit_index), 32'd0);
        repeat (3) @(negedge FPGA_Clk);
        FPGA_Rst_n = 1'b1;
        #1;
        chk("rst_query_ready", 32'(query_ready), 32'd1);

        run_query(10'd45,  10'd25,  1'b1, 4'd0,  1,  "q_card0", 5, 1'b0);
        run_query(10'd400, 10'd365, 1'b1, 4'd15, 16, "q_card15", 0, 1'b0);
        run_query(10'd359, 10'd365, 1'b1, 4'd14, 15, "q_card14_lastx", 0, 1'b0);
        run_query(10'd360, 10'd365, 1'b0, 4'd0,  16, "q_gap_14_15", 0, 1'b0);
        run_query(10'd120, 10'd25,  1'b0, 4'd0,  16, "q_xedge_miss", 0, 1'b0);
        run_query(10'd40,  10'd120, 1'b0, 4'd0,  16, "q_yedge_miss", 0, 1'b0);

        card_active[5] = 1'b0;
        run_query(10'd170, 10'd140, 1'b0, 4'd0, 16, "q_card5_inactive", 0, 1'b0);
        card_active[5] = 1'b1;
        run_query(10'd170, 10'd140, 1'b1, 4'd5, 6,  "q_card5_active", 0, 1'b0);

        card_active = '0;
        run_query(10'd45, 10'd25, 1'b0, 4'd0, 16, "q_none_active", 0, 1'b0);
        set_layout();

        cardX_bus[20 +: 10] = 10'd200;
        cardY_bus[20 +: 10] = 10'd200;
        cardX_bus[70 +: 10] = 10'd200;
        cardY_bus[70 +: 10] = 10'd200;
        run_query(10'd210, 10'd210, 1'b1, 4'd2, 3, "q_overlap", 0, 1'b0);
        set_layout();

        cardX_bus[30 +: 10] = 10'd1000;
        run_query(10'd1023, 10'd21, 1'b1, 4'd3, 4, "q_wide_sum", 0, 1'b0);
        set_layout();

        run_query(10'd400, 10'd365, 1'b1, 4'd15, 16, "q_perturb", 0, 1'b1);

        // Reset in the middle of a scan: previous result (hit=1) must clear at once.
        @(negedge FPGA_Clk);
        queryX      = 10'd400;
        queryY      = 10'd365;
        query_valid = 1'b1;
        @(posedge FPGA_Clk);
        #1;
        query_valid = 1'b0;
        repeat (5) @(posedge FPGA_Clk);
        #2;
        FPGA_Rst_n = 1'b0;
        #1;
        chk("midscan_rst_rv", 32'(result_valid), 32'd0);
        chk("midscan_rst_hit", 32'(hit), 32'd0);
        chk("midscan_rst_idx", 32'(hit_index), 32'd0);
        @(negedge FPGA_Clk);
        FPGA_Rst_n = 1'b1;
        #1;
        chk("midscan_rst_qr", 32'(query_ready), 32'd1);
        spurious = 0;
        repeat (20) begin
            @(posedge FPGA_Clk);
            #1;
            if (result_valid) spurious++;
        end
        chk("midscan_rst_no_result", 32'(spurious), 32'd0);

        run_query(10'd45, 10'd25, 1'b1, 4'd0, 1, "q_after_rst", 0, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
